// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection sequencer: demand-actuated side road, latched pedestrian
// walk phase and enforced all-red clearance; outputs registered from next-state.
module traffic_phase_scheduler #(
    parameter int TICK_DIV     = 100000000,
    parameter int A_GREEN_MIN  = 4,
    parameter int B_GREEN_TIME = 3,
    parameter int YELLOW_TIME  = 1,
    parameter int ALL_RED_TIME = 1,
    parameter int WALK_TIME    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_b,
    input  logic       ped_req,
    output logic [5:0] light,
    output logic       walk,
    output logic [2:0] phase,
    output logic       ped_ack
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        ALL_RED  = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        PED_WALK = 3'd5
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t        state, state_nx;
    logic          next_road, next_road_nx;   // 0 = road A, 1 = road B
    logic          ped_pend, ped_pend_nx;
    logic [PW-1:0] prescaler;
    logic [7:0]    timer;
    logic [7:0]    dur_last;
    logic          tick, at_end, moving, entering_walk;
    logic [5:0]    light_nx;

    always_comb begin
        tick = (prescaler == PRE_LAST);
        case (state)
            A_GREEN:  dur_last = 8'(A_GREEN_MIN - 1);
            A_YELLOW: dur_last = 8'(YELLOW_TIME - 1);
            ALL_RED:  dur_last = 8'(ALL_RED_TIME - 1);
            B_GREEN:  dur_last = 8'(B_GREEN_TIME - 1);
            B_YELLOW: dur_last = 8'(YELLOW_TIME - 1);
            PED_WALK: dur_last = 8'(WALK_TIME - 1);
            default:  dur_last = 8'd0;
        endcase
        at_end = tick && (timer == dur_last);
    end

    always_comb begin
        state_nx     = state;
        next_road_nx = next_road;
        case (state)
            A_GREEN: begin
                if (at_end && (car_b || ped_pend)) begin
                    state_nx     = A_YELLOW;
                    next_road_nx = 1'b1;
                end
            end
            A_YELLOW: if (at_end) state_nx = ALL_RED;
            ALL_RED: begin
                if (at_end) begin
                    if (ped_pend)       state_nx = PED_WALK;
                    else if (next_road) state_nx = B_GREEN;
                    else                state_nx = A_GREEN;
                end
            end
            B_GREEN: begin
                if (at_end) begin
                    state_nx     = B_YELLOW;
                    next_road_nx = 1'b0;
                end
            end
            B_YELLOW: if (at_end) state_nx = ALL_RED;
            PED_WALK: if (at_end) state_nx = next_road ? B_GREEN : A_GREEN;
            default: begin
                state_nx     = ALL_RED;
                next_road_nx = 1'b0;
            end
        endcase

        moving        = (state_nx != state);
        entering_walk = (state_nx == PED_WALK) && (state != PED_WALK);
        // A request on the walk-entry edge wins over the clear.
        ped_pend_nx   = ped_req | (ped_pend & ~entering_walk);

        case (state_nx)
            A_GREEN:  light_nx = 6'b100001;
            A_YELLOW: light_nx = 6'b010001;
            B_GREEN:  light_nx = 6'b001100;
            B_YELLOW: light_nx = 6'b001010;
            default:  light_nx = 6'b001001;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ALL_RED;
            next_road <= 1'b0;
            ped_pend  <= 1'b0;
            prescaler <= '0;
            timer     <= '0;
            light     <= 6'b001001;
            walk      <= 1'b0;
            phase     <= 3'd2;
            ped_ack   <= 1'b0;
        end else begin
            state     <= state_nx;
            next_road <= next_road_nx;
            ped_pend  <= ped_pend_nx;
            light     <= light_nx;
            walk      <= (state_nx == PED_WALK);
            phase     <= state_nx;
            ped_ack   <= entering_walk;

            if (moving || tick) prescaler <= '0;
            else                prescaler <= prescaler + 1'b1;

            // Timer saturates at the last tick so A_GREEN can hold indefinitely.
            if (moving)                          timer <= '0;
            else if (tick && timer != dur_last)  timer <= timer + 8'd1;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Randomised bench for traffic_phase_scheduler against a cycle-count phase model
// plus continuous safety checks on the lamp outputs.
module tb_traffic_phase_scheduler;

    localparam int TD   = 4;
    localparam int AMIN = 4;
    localparam int BG   = 3;
    localparam int YEL  = 1;
    localparam int AR   = 1;
    localparam int WK   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_b = 1'b0;
    logic       ped_req = 1'b0;
    logic [5:0] light;
    logic       walk;
    logic [2:0] phase;
    logic       ped_ack;

    int total = 0;
    int bad   = 0;

    traffic_phase_scheduler #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .car_b   (car_b),
        .ped_req (ped_req),
        .light   (light),
        .walk    (walk),
        .phase   (phase),
        .ped_ack (ped_ack)
    );

    always #5 clk = ~clk;

    // Reference: phase index 0..5, cycles spent in phase, road to serve next.
    int m_phase = 2;
    int m_cnt   = 0;
    bit m_next_b = 1'b0;
    bit m_pend   = 1'b0;
    bit m_ack    = 1'b0;

    logic [5:0] lamp_tab [6] = '{6'b100001, 6'b010001, 6'b001001,
                                 6'b001100, 6'b001010, 6'b001001};

    always @(posedge clk or negedge rst_n) begin
        int done;
        int np;
        if (!rst_n) begin
            m_phase = 2; m_cnt = 0; m_next_b = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
        end else begin
            done = m_cnt + 1;
            np   = m_phase;
            case (m_phase)
                0: if (done % TD == 0 && done / TD >= AMIN && (car_b || m_pend)) begin
                       np = 1; m_next_b = 1'b1;
                   end
                1: if (done == YEL * TD) np = 2;
                2: if (done == AR * TD) np = m_pend ? 5 : (m_next_b ? 3 : 0);
                3: if (done == BG * TD) begin np = 4; m_next_b = 1'b0; end
                4: if (done == YEL * TD) np = 2;
                5: if (done == WK * TD) np = m_next_b ? 3 : 0;
                default: np = 2;
            endcase
            m_ack  = (np == 5) && (m_phase != 5);
            m_pend = ped_req || (m_pend && !m_ack);
            m_cnt  = (np != m_phase) ? 0 : done;
            m_phase = np;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("light",   32'(light),   32'(lamp_tab[m_phase]));
        check("phase",   32'(phase),   32'(m_phase));
        check("walk",    32'(walk),    32'(m_phase == 5));
        check("ped_ack", 32'(ped_ack), 32'(m_ack));
        check("one_red_min", 32'(light[3] | light[0]), 32'd1);
        check("onehot_a", 32'($countones(light[5:3])), 32'd1);
        check("onehot_b", 32'($countones(light[2:0])), 32'd1);
        check("phase_legal", 32'(phase < 3'd6), 32'd1);
        if (walk) check("walk_all_red", 32'(light), 32'h09);
    endtask

    task automatic run(input int n, input logic car, input logic ped);
        for (int i = 0; i < n; i++) begin
            car_b   = car;
            ped_req = ped;
            @(negedge clk);
            check_outputs();
        end
    endtask

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        run(120, 1'b0, 1'b0);          // ALL_RED then indefinite A_GREEN hold
        run(6, 1'b0, 1'b0);
        run(60, 1'b1, 1'b0);           // B demand cycle
        run(30, 1'b0, 1'b0);
        run(1, 1'b0, 1'b1);            // single pedestrian pulse
        run(80, 1'b0, 1'b0);

        guard = 0;                     // hold ped_req across walk entry
        while (!m_ack && guard < 400) begin
            run(1, 1'b0, 1'b1);
            guard++;
        end
        check("walk_entry_seen", 32'(m_ack), 32'd1);
        run(3, 1'b0, 1'b1);
        run(150, 1'b0, 1'b0);

        guard = 0;                     // reset mid B_GREEN
        while (m_phase != 3 && guard < 400) begin
            run(1, 1'b1, 1'b0);
            guard++;
        end
        check("reach_b_green", 32'(m_phase), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_light", 32'(light), 32'h09);
        check("async_phase", 32'(phase), 32'd2);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        run(120, 1'b0, 1'b0);

        for (int i = 0; i < 20000; i++)
            run(1, ($urandom_range(0, 3) == 0) ? ~car_b : car_b, ($urandom_range(0, 99) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
